// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the Wishbone slave memory.
//   - FSM state encoding (IDLE/WAIT/RESP)
//   - response-kind encoding (NONE/ACK/ERR/RTY)
//   - address window decode helper
package wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // RESP_NONE means "in window but backend busy": keep stalling.
    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_ACK  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] RESP_RTY  = 2'd3;

    // The window is decoded in a wide type so BASE_ADDR + span cannot wrap.
    localparam int WIN_W = 64;

    function automatic logic in_window(input logic [WIN_W-1:0] adr,
                                       input logic [WIN_W-1:0] base,
                                       input logic [WIN_W-1:0] span);
        return (adr >= base) && (adr < (base + span));
    endfunction

endpackage

// File: rtl/wb_slave_regfile.sv
// wb_slave_regfile: DEPTH x DATA_WIDTH register file with byte-lane writes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears every word)
//   we_i, sel_i   write enable and byte-lane enables
//   idx_i         word index for both read and write
//   wdat_i        write data
//   re_i          read enable; rdat_o is registered and holds between reads
//   rdat_o        registered read data
module wb_slave_regfile #(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic [SELECT_WIDTH-1:0]    sel_i,
    input  logic [$clog2(DEPTH)-1:0]   idx_i,
    input  logic [DATA_WIDTH-1:0]      wdat_i,
    input  logic                       re_i,
    output logic [DATA_WIDTH-1:0]      rdat_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < SELECT_WIDTH; b++) begin
                if (sel_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdat_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdat_q <= '0;
        end else if (re_i) begin
            rdat_q <= mem_q[idx_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/wishbone_slave_mem.sv
// wishbone_slave_mem: single-beat Wishbone responder backed by a register file.
// Decodes a base-relative window, inserts WAIT_STATES wait cycles and answers
// each request with exactly one ACK, ERR or RTY pulse.
// Build option: define WB_SLAVE_RETRY_EN to answer a busy backend with RTY;
// otherwise busy_i stalls the response and wb_rty_o is tied low.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wb_adr_i/dat_i/we_i/sel_i request address, write data, direction, lanes
//   wb_stb_i, wb_cyc_i        strobe / cycle
//   wb_tgd_i, wb_tgd_o        request tag in, echoed with the response
//   wb_dat_o                  read data, valid with wb_ack_o, held until next read
//   wb_ack_o/err_o/rty_o      one-cycle termination pulses
//   busy_i                    backend busy, blocks completion
//   wr_strobe_o, wr_index_o   pulse and word index of each committed write
//
// state | meaning
// IDLE  | waiting for cyc & stb
// WAIT  | counting wait states, or stalled on busy_i
// RESP  | termination pulse on the bus, back to IDLE next cycle
module wishbone_slave_mem
    import wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int                    TAG_WIDTH    = 1,
    parameter int                    DEPTH        = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    WAIT_STATES  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      wb_adr_i,
    input  logic [DATA_WIDTH-1:0]      wb_dat_i,
    output logic [DATA_WIDTH-1:0]      wb_dat_o,
    input  logic                       wb_we_i,
    input  logic [SELECT_WIDTH-1:0]    wb_sel_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_cyc_i,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic                       wb_rty_o,
    input  logic [TAG_WIDTH-1:0]       wb_tgd_i,
    output logic [TAG_WIDTH-1:0]       wb_tgd_o,
    input  logic                       busy_i,
    output logic                       wr_strobe_o,
    output logic [$clog2(DEPTH)-1:0]   wr_index_o
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam int               SEL_LSB = $clog2(SELECT_WIDTH);
    localparam logic [WIN_W-1:0] SPAN    = WIN_W'(DEPTH * SELECT_WIDTH);
    // Counter is loaded with WAIT_STATES-1 so the response is registered on the
    // edge where it reads 0, giving 1 + WAIT_STATES cycles of latency.
    localparam logic [3:0]       WS_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [1:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [TAG_WIDTH-1:0]    req_tgd_q, req_tgd_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [TAG_WIDTH-1:0]    tgd_o_q, tgd_o_d;
    logic                    wr_strobe_q, wr_strobe_d;
    logic [IDX_W-1:0]        wr_index_q, wr_index_d;
`ifdef WB_SLAVE_RETRY_EN
    logic                    rty_q, rty_d;
`endif

    // In IDLE with no wait states the response is decided from the live bus;
    // afterwards from the captured request.
    logic [ADDR_WIDTH-1:0]   cur_adr;
    logic [DATA_WIDTH-1:0]   cur_dat;
    logic                    cur_we;
    logic [SELECT_WIDTH-1:0] cur_sel;
    logic [TAG_WIDTH-1:0]    cur_tgd;
    logic [IDX_W-1:0]        cur_idx;
    logic                    in_win;
    logic [1:0]              resp_kind;
    logic                    eval;
    logic                    mem_we;
    logic                    mem_re;

    assign cur_adr = (state_q == ST_IDLE) ? wb_adr_i : adr_q;
    assign cur_dat = (state_q == ST_IDLE) ? wb_dat_i : dat_q;
    assign cur_we  = (state_q == ST_IDLE) ? wb_we_i  : we_q;
    assign cur_sel = (state_q == ST_IDLE) ? wb_sel_i : sel_q;
    assign cur_tgd = (state_q == ST_IDLE) ? wb_tgd_i : req_tgd_q;

    assign in_win  = in_window(WIN_W'(cur_adr), WIN_W'(BASE_ADDR), SPAN);
    assign cur_idx = IDX_W'((cur_adr - BASE_ADDR) >> SEL_LSB);

    always_comb begin
        resp_kind = RESP_ACK;
        if (!in_win) begin
            resp_kind = RESP_ERR;
        end else if (busy_i) begin
`ifdef WB_SLAVE_RETRY_EN
            resp_kind = RESP_RTY;
`else
            resp_kind = RESP_NONE;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        sel_d       = sel_q;
        req_tgd_d   = req_tgd_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        tgd_o_d     = tgd_o_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        eval        = 1'b0;
`ifdef WB_SLAVE_RETRY_EN
        rty_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d     = wb_adr_i;
                    dat_d     = wb_dat_i;
                    we_d      = wb_we_i;
                    sel_d     = wb_sel_i;
                    req_tgd_d = wb_tgd_i;
                    if (WAIT_STATES == 0) begin
                        eval = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                // A withdrawn request is dropped silently; a response is never
                // driven against a low strobe.
                if (!wb_cyc_i || !wb_stb_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    eval = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (eval) begin
            case (resp_kind)
                RESP_ERR: begin
                    err_d   = 1'b1;
                    tgd_o_d = cur_tgd;
                    state_d = ST_RESP;
                end
                RESP_ACK: begin
                    ack_d   = 1'b1;
                    tgd_o_d = cur_tgd;
                    state_d = ST_RESP;
                    if (cur_we) begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_index_d  = cur_idx;
                    end else begin
                        mem_re = 1'b1;
                    end
                end
`ifdef WB_SLAVE_RETRY_EN
                RESP_RTY: begin
                    rty_d   = 1'b1;
                    tgd_o_d = cur_tgd;
                    state_d = ST_RESP;
                end
`endif
                default: begin
                    // Busy stall: re-evaluate every cycle from WAIT.
                    state_d = ST_WAIT;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            req_tgd_q   <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            tgd_o_q     <= '0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            req_tgd_q   <= req_tgd_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            tgd_o_q     <= tgd_o_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
        end
    end

`ifdef WB_SLAVE_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rty_q <= 1'b0;
        end else begin
            rty_q <= rty_d;
        end
    end
    assign wb_rty_o = rty_q;
`else
    assign wb_rty_o = 1'b0;
`endif

    wb_slave_regfile #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SELECT_WIDTH (SELECT_WIDTH),
        .DEPTH        (DEPTH)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we_i   (mem_we),
        .sel_i  (cur_sel),
        .idx_i  (cur_idx),
        .wdat_i (cur_dat),
        .re_i   (mem_re),
        .rdat_o (wb_dat_o)
    );

    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_tgd_o    = tgd_o_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_index_o  = wr_index_q;

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Bench for wishbone_slave_mem: two instances (WAIT_STATES 0 and 3) share the
// request bus; each is selected by its own cyc. Expected responses come from a
// small memory model and are queued when a request is driven.
module tb_wishbone_slave_mem;

    localparam logic [2:0] K_ACK = 3'b100;
    localparam logic [2:0] K_ERR = 3'b010;
    localparam logic [2:0] K_RTY = 3'b001;
`ifdef WB_SLAVE_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] dat;
        logic        tgd;
        logic        strobe;
        logic [3:0]  idx;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr_b = '0;
    logic [31:0] dat_b = '0;
    logic        we_b  = 1'b0;
    logic [3:0]  sel_b = '0;
    logic        stb_b = 1'b0;
    logic [1:0]  cyc_b = '0;
    logic        tgd_b = 1'b0;
    logic        busy  = 1'b0;

    logic [31:0] dat_o [2];
    logic [1:0]  ack_o, err_o, rty_o, tgd_o, wrs_o;
    logic [3:0]  wri_o [2];

    logic [31:0] mdl [2][16];
    logic [31:0] last_rd [2];
    exp_t        sb [$];
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    wishbone_slave_mem #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .wb_adr_i(adr_b), .wb_dat_i(dat_b), .wb_dat_o(dat_o[0]),
        .wb_we_i(we_b), .wb_sel_i(sel_b), .wb_stb_i(stb_b), .wb_cyc_i(cyc_b[0]),
        .wb_ack_o(ack_o[0]), .wb_err_o(err_o[0]), .wb_rty_o(rty_o[0]),
        .wb_tgd_i(tgd_b), .wb_tgd_o(tgd_o[0]), .busy_i(busy),
        .wr_strobe_o(wrs_o[0]), .wr_index_o(wri_o[0])
    );

    wishbone_slave_mem #(.WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst(rst), .wb_adr_i(adr_b), .wb_dat_i(dat_b), .wb_dat_o(dat_o[1]),
        .wb_we_i(we_b), .wb_sel_i(sel_b), .wb_stb_i(stb_b), .wb_cyc_i(cyc_b[1]),
        .wb_ack_o(ack_o[1]), .wb_err_o(err_o[1]), .wb_rty_o(rty_o[1]),
        .wb_tgd_i(tgd_b), .wb_tgd_o(tgd_o[1]), .busy_i(busy),
        .wr_strobe_o(wrs_o[1]), .wr_index_o(wri_o[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] resp_vec(input int d);
        return {ack_o[d], err_o[d], rty_o[d]};
    endfunction

    function automatic logic [49:0] all_outs(input int d);
        return {ack_o[d], err_o[d], rty_o[d], tgd_o[d], wrs_o[d], wri_o[d], dat_o[d], 8'h00};
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < 16; i++) mdl[d][i] = '0;
        end
    endtask

    // Called right after a negedge. busy_cyc > 0 holds busy_i high for that
    // many sampling edges starting with the request edge.
    task automatic xfer(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic tgd, input int busy_cyc);
        exp_t e;
        int ws, k;
        logic [3:0] idx;
        logic seen, spur;
        ws  = (d == 0) ? 0 : 3;
        idx = adr[5:2];
        if (adr >= 32'h40)               e.kind = K_ERR;
        else if (RETRY && busy_cyc > ws) e.kind = K_RTY;
        else                             e.kind = K_ACK;
        e.lat    = (e.kind == K_ACK) ? 1 + ((ws > busy_cyc) ? ws : busy_cyc) : 1 + ws;
        e.tgd    = tgd;
        e.idx    = idx;
        e.strobe = (e.kind == K_ACK) && we;
        if (e.kind == K_ACK) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mdl[d][idx][b*8 +: 8] = dat[b*8 +: 8];
            end else begin
                last_rd[d] = mdl[d][idx];
            end
        end
        e.dat = last_rd[d];
        sb.push_back(e);

        adr_b = adr; dat_b = dat; we_b = we; sel_b = sel; tgd_b = tgd;
        stb_b = 1'b1; cyc_b[d] = 1'b1; busy = (busy_cyc > 0);
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == busy_cyc) busy = 1'b0;
            if (ack_o[d] | err_o[d] | rty_o[d]) seen = 1'b1;
        end
        e = sb.pop_front();
        check("latency", 64'(k), 64'(e.lat));
        check("resp_kind", 64'(resp_vec(d)), 64'(e.kind));
        check("rd_data", 64'(dat_o[d]), 64'(e.dat));
        check("tag", 64'(tgd_o[d]), 64'(e.tgd));
        check("wr_strobe", 64'(wrs_o[d]), 64'(e.strobe));
        if (e.strobe) check("wr_index", 64'(wri_o[d]), 64'(e.idx));
        // stb is still high across the RESP->IDLE edge
        @(negedge clk);
        check("one_cycle", 64'({resp_vec(d), wrs_o[d]}), 64'(0));
        stb_b = 1'b0; cyc_b[d] = 1'b0; busy = 1'b0;
        spur = 1'b0;
        repeat (ws + 2) begin
            @(negedge clk);
            spur = spur | ack_o[d] | err_o[d] | rty_o[d] | wrs_o[d];
        end
        check("no_extra_resp", 64'(spur), 64'(0));
    endtask

    task automatic abort_write(input int d, input logic [31:0] adr, input logic [31:0] dat);
        logic spur;
        adr_b = adr; dat_b = dat; we_b = 1'b1; sel_b = 4'hF; tgd_b = 1'b0;
        stb_b = 1'b1; cyc_b[d] = 1'b1;
        repeat (2) @(negedge clk);
        cyc_b[d] = 1'b0; stb_b = 1'b0;
        spur = 1'b0;
        repeat (6) begin
            @(negedge clk);
            spur = spur | ack_o[d] | err_o[d] | rty_o[d] | wrs_o[d];
        end
        check("abort_silent", 64'(spur), 64'(0));
    endtask

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check("reset_dut0", 64'(all_outs(0)), 64'(0));
        check("reset_dut3", 64'(all_outs(1)), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // zero wait states
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 0);
        xfer(0, 1'b0, 32'h08, 32'h0,        4'hF, 1'b0, 0);
        xfer(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 1'b0, 0);
        xfer(0, 1'b0, 32'h08, 32'h0,        4'h0, 1'b0, 0);
        check("byte_lane_model", 64'(mdl[0][2]), 64'hDE22BE44);
        xfer(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 1'b1, 0);
        xfer(0, 1'b0, 32'h0B, 32'h0,        4'h0, 1'b0, 0);
        xfer(0, 1'b1, 32'h3C, 32'hA5A5A5A5, 4'hF, 1'b0, 0);
        xfer(0, 1'b0, 32'h3E, 32'h0,        4'h1, 1'b0, 0);
        // out of window: ERR, memory at the aliased index untouched
        xfer(0, 1'b1, 32'h40, 32'h55555555, 4'hF, 1'b1, 0);
        xfer(0, 1'b0, 32'h00, 32'h0,        4'hF, 1'b0, 0);
        // backend busy
        xfer(0, 1'b0, 32'h08, 32'h0,        4'hF, 1'b1, 5);
        xfer(0, 1'b0, 32'h08, 32'h0,        4'hF, 1'b0, 0);
        xfer(0, 1'b1, 32'h04, 32'h0BADF00D, 4'hF, 1'b0, 3);
        xfer(0, 1'b0, 32'h04, 32'h0,        4'hF, 1'b0, 0);

        // three wait states
        xfer(1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF, 1'b0, 0);
        xfer(1, 1'b0, 32'h0C, 32'h0,        4'hF, 1'b1, 0);
        abort_write(1, 32'h0C, 32'h12345678);
        xfer(1, 1'b0, 32'h0C, 32'h0,        4'hF, 1'b0, 0);
        xfer(1, 1'b1, 32'h10, 32'h01020304, 4'b1000, 1'b0, 0);
        xfer(1, 1'b0, 32'h10, 32'h0,        4'hF, 1'b0, 0);
        xfer(1, 1'b0, 32'hFFFFFFFC, 32'h0,  4'hF, 1'b1, 0);

        // reset while a write is in WAIT
        adr_b = 32'h0C; dat_b = 32'h77777777; we_b = 1'b1; sel_b = 4'hF; tgd_b = 1'b1;
        stb_b = 1'b1; cyc_b[1] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_dut3", 64'(all_outs(1)), 64'(0));
        check("midreset_dut0", 64'(all_outs(0)), 64'(0));
        stb_b = 1'b0; cyc_b = '0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        xfer(1, 1'b0, 32'h0C, 32'h0, 4'hF, 1'b0, 0);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wishbone_slave_mem.md
# wishbone_slave_mem

Wishbone responder that terminates single-beat transactions from the team's Wishbone master and backs them with an internal byte-lane register file. It decodes a base-relative window, applies programmable wait states and answers every request with exactly one ACK, ERR or RTY pulse. It sits on the slave side of a point-to-point Wishbone link, or behind an interconnect, and is the standard peripheral/scratch-RAM endpoint.

## Interface
Parameters:
- ADDR_WIDTH, 32: bus address width.
- DATA_WIDTH, 32: bus data width (multiple of 8).
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width.
- TAG_WIDTH, 1: data-tag width.
- DEPTH, 16: number of words in the register file (power of 2, ≥ 2).
- BASE_ADDR, 0: byte address of word 0 (aligned to DEPTH*SELECT_WIDTH).
- WAIT_STATES, 0: extra cycles inserted before the response (0–15).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data, valid with wb_ack_o.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  SELECT_WIDTH  byte enables.
- wb_stb_i, wb_cyc_i  in  1  strobe / cycle.
- wb_ack_o, wb_err_o, wb_rty_o  out  1  termination pulses.
- wb_tgd_i  in  TAG_WIDTH  request tag.
- wb_tgd_o  out  TAG_WIDTH  tag echoed with the response.
- busy_i  in  1  backend busy; blocks completion.
- wr_strobe_o  out  1  one-cycle pulse on each committed write.
- wr_index_o  out  $clog2(DEPTH)  word index of the committed write.

## Operation
- Reset: state IDLE; wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, wb_tgd_o, wr_strobe_o, wr_index_o all 0; every register-file word cleared to 0.
- States: IDLE, WAIT, RESP.
- IDLE: when wb_cyc_i & wb_stb_i are sampled high, capture adr/dat/we/sel/tgd and load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES > 0, else evaluate the response immediately.
- WAIT: decrement the counter each cycle. When it reaches 0, evaluate the response.
- Response priority:
  1. Out of window (adr < BASE_ADDR or adr ≥ BASE_ADDR + DEPTH*SELECT_WIDTH) → ERR.
  2. busy_i high → hold (see Configuration).
  3. Otherwise → ACK.
- Word index = (adr − BASE_ADDR) >> log2(SELECT_WIDTH). Low address bits are ignored; unaligned accesses are not errors.
- ACK on a write: update only the bytes enabled in wb_sel_i, in the cycle ACK is registered. wr_strobe_o and wr_index_o are asserted in the same cycle as ACK.
- ACK on a read: wb_dat_o = the full word; sel is ignored. wb_dat_o holds its value until the next read ACK.
- sel = 0 on a write: ACK with no data change, and wr_strobe_o still pulses.
- RESP: exactly one of ack/err/rty is high for exactly one cycle, and wb_tgd_o is valid. The next state is IDLE unconditionally. The stb still high on that edge must not start a new transaction.
- wb_cyc_i drops in WAIT: abort, return to IDLE, no response, no write.
- ERR and RTY never modify the register file or pulse wr_strobe_o.

## Timing
- Latency: first response cycle is 1 + WAIT_STATES cycles after the edge that samples stb&cyc high, plus any busy_i stall cycles.
- The earliest next request is sampled on the edge after RESP. Back-to-back throughput is 2 + WAIT_STATES cycles per access.
- The master drops stb in the cycle after it sees the response. No response is ever emitted while stb is low.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously and any pending write is discarded.

## Configuration
- WB_SLAVE_RETRY_EN undefined: busy_i high at response time stalls in WAIT (no termination) until busy_i is sampled low, then ACK. wb_rty_o is tied 0.
- WB_SLAVE_RETRY_EN defined: busy_i high at response time produces a one-cycle RTY instead. The master re-issues the request, and the full WAIT_STATES latency applies again.

## Structure
- Shared package wb_pkg:
  - state encoding localparams (IDLE/WAIT/RESP);
  - response-kind constants (ACK/ERR/RTY);
  - the window-decode helper function.
- Sub-module wb_slave_regfile: DEPTH×DATA_WIDTH array with byte-lane write enables, async reset clear and a registered read port. The FSM lives in the top module.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF, sel 0xF to 0x08 → ACK 1 cycle after stb sampled, wr_strobe_o=1, wr_index_o=2. Read 0x08 → 0xDEADBEEF with ACK.
- Byte lanes: write 0x11223344, sel 0b0101 over 0xDEADBEEF at 0x08 → read returns 0xDE22BE44.
- WAIT_STATES=3: read → ACK exactly 4 cycles after stb sampled. Drop cyc after 2 cycles → no response, next request served normally.
- Address 0x40 with DEPTH=16 → single ERR pulse, no ACK, memory unchanged. Tag 1 is echoed on wb_tgd_o.
- busy_i held 5 cycles: without the macro, ACK arrives 5 cycles late. With WB_SLAVE_RETRY_EN, an RTY pulse with no write, and the re-issued request gets ACK once busy_i is low.
- Reset pulsed during WAIT of a write → all outputs 0, no ACK, and a subsequent read of that address returns 0.
